rsa_crypt_core: RTL
===================

Name: rsa_crypt_core

Overview:
Parametrised RSA modular-exponentiation engine. Computes out = msg^key mod modulus and selects the public (encrypt) or private (decrypt) exponent per transaction. It uses valid/ready handshakes on input and output, and contains its own bit-serial shift-add modular multiplier. It sits between the host command interface and the transmit framer, and replaces the fixed 16-bit encrypt-only controller.

Parameters:
WIDTH, 16, bit width of msg, modulus and result
EXP_WIDTH, 16, bit width of key_e / key_d; all EXP_WIDTH bits are processed, LSB first

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  request present
in_ready  out  1  core can accept a request
mode  in  1  0 = encrypt (use key_e), 1 = decrypt (use key_d)
msg  in  WIDTH  plaintext or ciphertext
key_e  in  EXP_WIDTH  public exponent
key_d  in  EXP_WIDTH  private exponent
modulus  in  WIDTH  n
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
out_data  out  WIDTH  result
out_err  out  1  qualifies out_valid: request rejected
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: in_ready=0 while rst is high, 1 in the first IDLE cycle after release; out_valid=0, out_data=0, out_err=0, busy=0; state=IDLE; all datapath registers 0.
- Acceptance edge = rising edge with in_valid && in_ready. At that edge, latch msg, modulus, and the exponent selected by mode, then go to CHECK. Inputs are ignored at all other times.
- in_ready = (state==IDLE). A new request is never accepted while busy.
- States: IDLE -> CHECK -> {ERR | EXP} ; EXP -> MUL -> SQR -> (EXP or DONE) ; DONE/ERR -> IDLE.
- CHECK (1 cycle): if modulus<2 or msg>=modulus, go to ERR. Otherwise set result=1, base=msg, bit index=0, and go to EXP.
- ERR: out_valid=1, out_err=1, out_data=0. Hold until out_ready, then go to IDLE.
- EXP (0 cycles, decision only): examine exponent bit[idx]. If set, go to MUL; if clear, go to SQR (see optional feature).
- MUL (WIDTH cycles): result = result*base mod n via the modmul below.
- SQR (WIDTH cycles): base = base*base mod n. Then idx++. If idx==EXP_WIDTH, go to DONE, else go to EXP.
- Squaring is performed for every bit, including leading zeros; latency depends only on EXP_WIDTH and the exponent popcount.
- modmul(a,b): acc=0; for i=WIDTH-1 downto 0, one bit per cycle:
  - t=2*acc; if t>=n then t-=n
  - if b[i] then t+=a; if t>=n then t-=n
  - acc=t
  - Internal width WIDTH+2. Operands are always <n, so the result is always <n.
- DONE: out_valid=1, out_err=0, out_data=result. out_data and out_err stay stable while out_valid && !out_ready. Go to IDLE on the edge with out_valid && out_ready.
- Latency, acceptance edge to the edge where out_valid rises:
  - normal path: 1 + WIDTH*(EXP_WIDTH + popcount(exp))
  - error path: 1
- Exponent 0: result=1 (n>=2 guaranteed by CHECK).
- msg=0 with exp>0: result=0.
- rst asserted mid-operation: abort immediately, all outputs return to their reset values, and no result is emitted.
- out_ready asserted while out_valid is low has no effect.
- out_valid drops on the cycle after the handshake edge. in_ready rises in that same cycle.

Optional Feature:
Macro: RSA_CONST_TIME_EN.
- Defined: EXP always goes to MUL. When the exponent bit is clear, the multiply still runs for WIDTH cycles, but its result is discarded and result is unchanged. Latency is then fixed at 1 + 2*WIDTH*EXP_WIDTH, which hides the key from timing side channels.
- Undefined: the MUL step is skipped for clear bits, per the EXP state above.

Test Plan:
- WIDTH=16, EXP_WIDTH=16, mode=0, msg=65, key_e=17, modulus=3233 -> out_data=2790, out_err=0. out_valid rises 289 edges after acceptance (no macro) or 513 edges (RSA_CONST_TIME_EN).
- mode=1, msg=2790, key_d=2753, modulus=3233 -> out_data=65. Also msg=4, key_e=13, modulus=497 -> out_data=445.
- key_e=0, msg=5, modulus=7 -> out_data=1. msg=0, key_e=3, modulus=7 -> out_data=0.
- modulus=1 -> out_valid=1, out_err=1, out_data=0 one edge after acceptance. msg=3233 with modulus=3233 -> same error response.
- Hold out_ready=0 for 10 cycles after out_valid: out_data and out_valid are stable and in_ready=0. A second in_valid pulse during busy is not accepted. Then out_ready=1: handshake completes and in_ready=1 on the next cycle.
- Assert rst 50 cycles into an encryption: outputs return to their reset values immediately. After release, a fresh request (65, 17, 3233) still returns 2790.

Source files
------------

// File: rtl/rsa_crypt_core.sv
// RSA modular exponentiation (msg^key mod modulus) with a bit-serial shift-add modular multiplier.
// Optional RSA_CONST_TIME_EN: run the multiply for every exponent bit so latency does not depend on the key.
module rsa_crypt_core #(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     msg,
  input  logic [EXP_WIDTH-1:0] key_e,
  input  logic [EXP_WIDTH-1:0] key_d,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_err,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int IW = $clog2(EXP_WIDTH + 1);
  localparam int AW = WIDTH + 2;

`ifdef RSA_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  // EXP is a zero-cycle decision, so it is folded into exp_state() rather than held as a state.
  typedef enum logic [2:0] {IDLE, CHECK, MUL, SQR, DONE, ERR} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     n_q, base_q, result_q, acc_q, acc_nxt, mul_a;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [IW-1:0]        idx_q;
  logic [CW-1:0]        cnt_q;
  logic                 mul_last, bad_req, last_bit, keep_mul;

  function automatic state_t exp_state(input logic bit_set);
    return (bit_set || CONST_TIME) ? MUL : SQR;
  endfunction

  assign mul_last = (cnt_q == '0);
  assign bad_req  = (n_q < WIDTH'(2)) || (base_q >= n_q);
  assign last_bit = (idx_q == IW'(EXP_WIDTH - 1));
  assign keep_mul = exp_q[0] || !CONST_TIME;
  assign mul_a    = (state == MUL) ? result_q : base_q;

  // One shift-add step of acc = a*b mod n, consuming base bit cnt_q (MSB first).
  always_comb begin
    logic [AW-1:0] t;
    t = {1'b0, acc_q, 1'b0};
    if (t >= {2'b0, n_q}) t = t - {2'b0, n_q};
    if (base_q[cnt_q])    t = t + {2'b0, mul_a};
    if (t >= {2'b0, n_q}) t = t - {2'b0, n_q};
    acc_nxt = WIDTH'(t);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = CHECK;
      CHECK: state_nxt = bad_req ? ERR : exp_state(exp_q[0]);
      MUL:   if (mul_last) state_nxt = SQR;
      SQR:   if (mul_last) state_nxt = last_bit ? DONE : exp_state(exp_q[1]);
      DONE:  if (out_ready) state_nxt = IDLE;
      ERR:   if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q      <= '0;
      base_q   <= '0;
      result_q <= '0;
      acc_q    <= '0;
      exp_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          base_q <= msg;
          n_q    <= modulus;
          exp_q  <= mode ? key_d : key_e;
        end
        CHECK: begin
          result_q <= WIDTH'(1);
          idx_q    <= '0;
          cnt_q    <= CW'(WIDTH - 1);
          acc_q    <= '0;
        end
        MUL, SQR: begin
          if (!mul_last) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q - 1'b1;
          end else begin
            acc_q <= '0;
            cnt_q <= CW'(WIDTH - 1);
            if (state == MUL) begin
              if (keep_mul) result_q <= acc_nxt;
            end else begin
              base_q <= acc_nxt;
              exp_q  <= exp_q >> 1;
              idx_q  <= idx_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE) || (state == ERR);
  assign out_err   = (state == ERR);
  assign out_data  = (state == DONE) ? result_q : '0;

endmodule
